// File: rtl/usb_in_packetizer_pkg.sv
// usb_in_packetizer_pkg
// Shared definitions for the USB IN-endpoint packetizer: the 2-bit FSM state
// encoding, the high-speed bulk maximum packet size and the width used for
// byte counts and committed lengths (wide enough to hold 512 itself).
package usb_in_packetizer_pkg;

  typedef enum logic [1:0] {
    WAIT_RDY = 2'd0,
    FILL     = 2'd1,
    COMMIT   = 2'd2
  } pkt_state_t;

  localparam int USB_MAX_PKT_HS = 512;
  localparam int LEN_W          = 10;

endpackage

// File: rtl/usb_in_packetizer.sv
// usb_in_packetizer
// Packs an 8-bit byte stream into USB IN endpoint buffer packets. Bytes are
// written one per cycle into the endpoint buffer; a packet is committed when it
// reaches MAX_PKT bytes, when a byte carries s_last, or on flush (a flush with
// nothing buffered commits a zero-length packet).
//
// Optional feature: define USB_IN_TIMEOUT_EN to flush a partial packet after
// TIMEOUT_CYC consecutive idle cycles in FILL.
//
// Ports
//   ext_clk            sole clock, rising edge
//   reset_n            asynchronous active-low reset
//   s_data/s_valid/s_ready/s_last   input byte stream, s_last ends a packet
//   flush              single-cycle request to commit buffered bytes
//   buf_in_addr/buf_in_data/buf_in_wren   endpoint buffer write port
//   buf_in_ready       endpoint buffer is free to be filled
//   buf_in_commit/buf_in_commit_len/buf_in_commit_ack   commit handshake
//   stat_busy          packet in progress or buffer not yet released
module usb_in_packetizer
  import usb_in_packetizer_pkg::*;
#(
  parameter int MAX_PKT     = USB_MAX_PKT_HS,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             ext_clk,
  input  logic             reset_n,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_last,
  input  logic             flush,
  output logic [8:0]       buf_in_addr,
  output logic [7:0]       buf_in_data,
  output logic             buf_in_wren,
  input  logic             buf_in_ready,
  output logic             buf_in_commit,
  output logic [LEN_W-1:0] buf_in_commit_len,
  input  logic             buf_in_commit_ack,
  output logic             stat_busy
);

  pkt_state_t       state;
  pkt_state_t       next_state;
  logic [LEN_W-1:0] count;
  logic             accept;
  logic             close_pkt;
  logic             timeout_hit;

  // State register.
  always_ff @(posedge ext_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= WAIT_RDY;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake logic. A flush arriving together with an accepted
  // byte closes the packet on that byte, exactly like s_last would.
  always_comb begin
    next_state = state;
    s_ready    = 1'b0;
    accept     = 1'b0;
    close_pkt  = 1'b0;
    case (state)
      WAIT_RDY: begin
        if (buf_in_ready && !buf_in_commit_ack) begin
          next_state = FILL;
        end
      end
      FILL: begin
        s_ready = (count < LEN_W'(MAX_PKT));
        accept  = s_valid && s_ready;
        if (accept) begin
          close_pkt = s_last || flush || (count == LEN_W'(MAX_PKT - 1));
        end else begin
          close_pkt = flush || timeout_hit;
        end
        if (close_pkt) begin
          next_state = COMMIT;
        end
      end
      COMMIT: begin
        if (buf_in_commit && buf_in_commit_ack) begin
          next_state = WAIT_RDY;
        end
      end
      default: begin
        next_state = WAIT_RDY;
      end
    endcase
  end

  // Write port and commit handshake. The write for a byte accepted at one edge
  // is presented for exactly the following cycle. Commit is raised on the first
  // edge spent in COMMIT, so it always trails the final write strobe by a cycle.
  always_ff @(posedge ext_clk or negedge reset_n) begin
    if (!reset_n) begin
      count             <= '0;
      buf_in_addr       <= '0;
      buf_in_data       <= '0;
      buf_in_wren       <= 1'b0;
      buf_in_commit     <= 1'b0;
      buf_in_commit_len <= '0;
    end else begin
      buf_in_wren <= accept;
      if (accept) begin
        buf_in_addr <= count[8:0];
        buf_in_data <= s_data;
        count       <= count + LEN_W'(1);
      end
      if (state == COMMIT) begin
        if (buf_in_commit && buf_in_commit_ack) begin
          buf_in_commit <= 1'b0;
          count         <= '0;
        end else if (!buf_in_commit) begin
          buf_in_commit     <= 1'b1;
          buf_in_commit_len <= count;
        end
      end
    end
  end

  assign stat_busy = (state != WAIT_RDY) || (count != '0);

`ifdef USB_IN_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // The idle cycle that would bring the count to TIMEOUT_CYC acts as a flush.
  assign timeout_hit = (state == FILL) && (count != '0) && !accept &&
                       (tmo_cnt == 16'(TIMEOUT_CYC - 1));

  // Idle-cycle counter; only runs while a partial packet sits in the buffer.
  always_ff @(posedge ext_clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if ((state != FILL) || (count == '0) || accept || timeout_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end
`else
  logic [31:0] unused_timeout_cyc;
  assign unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout_hit        = 1'b0;
`endif

endmodule

// File: tb/tb_usb_in_packetizer.sv
// tb_usb_in_packetizer
// Directed-plus-random bench for usb_in_packetizer. The reference model is a
// queue of bytes sent in the current packet: the expected writes are address i
// carrying the i-th byte, and the expected commit length is the queue size.
module tb_usb_in_packetizer;

  localparam int MAX_PKT = 512;
  localparam int TMO     = 16;

  logic       ext_clk = 1'b0;
  logic       reset_n;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       s_last;
  logic       flush;
  logic [8:0] buf_in_addr;
  logic [7:0] buf_in_data;
  logic       buf_in_wren;
  logic       buf_in_ready;
  logic       buf_in_commit;
  logic [9:0] buf_in_commit_len;
  logic       buf_in_commit_ack;
  logic       stat_busy;

  int checks = 0;
  int errors = 0;

  logic [16:0] obs_q[$];
  logic [7:0]  exp_q[$];

  usb_in_packetizer #(
    .MAX_PKT     (MAX_PKT),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .ext_clk           (ext_clk),
    .reset_n           (reset_n),
    .s_data            (s_data),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .s_last            (s_last),
    .flush             (flush),
    .buf_in_addr       (buf_in_addr),
    .buf_in_data       (buf_in_data),
    .buf_in_wren       (buf_in_wren),
    .buf_in_ready      (buf_in_ready),
    .buf_in_commit     (buf_in_commit),
    .buf_in_commit_len (buf_in_commit_len),
    .buf_in_commit_ack (buf_in_commit_ack),
    .stat_busy         (stat_busy)
  );

  always #5 ext_clk = ~ext_clk;

  // Capture every write strobe away from the active edge.
  always @(negedge ext_clk) begin
    if (buf_in_wren === 1'b1) begin
      obs_q.push_back({buf_in_addr, buf_in_data});
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge ext_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l,
                               input logic f);
    s_valid = v;
    s_data  = d;
    s_last  = l;
    flush   = f;
  endtask

  task automatic sendByte(input logic [7:0] d, input logic l, input logic f);
    checkOutput("s_ready_in_fill", {31'd0, s_ready}, 32'd1);
    applyStimulus(1'b1, d, l, f);
    exp_q.push_back(d);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput($sformatf("%s_s_ready", tag), {31'd0, s_ready}, 32'd0);
    checkOutput($sformatf("%s_wren", tag), {31'd0, buf_in_wren}, 32'd0);
    checkOutput($sformatf("%s_commit", tag), {31'd0, buf_in_commit}, 32'd0);
    checkOutput($sformatf("%s_addr", tag), {23'd0, buf_in_addr}, 32'd0);
    checkOutput($sformatf("%s_data", tag), {24'd0, buf_in_data}, 32'd0);
    checkOutput($sformatf("%s_len", tag), {22'd0, buf_in_commit_len}, 32'd0);
    checkOutput($sformatf("%s_busy", tag), {31'd0, stat_busy}, 32'd0);
  endtask

  // Waits (bounded) for commit, compares length and write log with the model,
  // acknowledges, and leaves the DUT back in FILL.
  task automatic finishPacket(input string tag, input int max_wait);
    int waited;
    int n;
    waited = 0;
    while (buf_in_commit !== 1'b1 && waited < max_wait) begin
      tick();
      waited++;
    end
    checkOutput($sformatf("%s_commit_seen", tag), {31'd0, buf_in_commit}, 32'd1);
    checkOutput($sformatf("%s_len", tag), {22'd0, buf_in_commit_len}, exp_q.size());
    checkOutput($sformatf("%s_nwrites", tag), obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_addr%0d", tag, i), {23'd0, obs_q[i][16:8]}, i);
      checkOutput($sformatf("%s_data%0d", tag, i), {24'd0, obs_q[i][7:0]},
                  {24'd0, exp_q[i]});
    end
    buf_in_commit_ack = 1'b1;
    tick();
    checkOutput($sformatf("%s_commit_drop", tag), {31'd0, buf_in_commit}, 32'd0);
    checkOutput($sformatf("%s_idle_busy", tag), {31'd0, stat_busy}, 32'd0);
    buf_in_commit_ack = 1'b0;
    obs_q.delete();
    exp_q.delete();
    tick();
    checkOutput($sformatf("%s_refill", tag), {31'd0, s_ready}, 32'd1);
  endtask

  initial begin
    int          plen;
    int          waited;
    logic [7:0]  d;

    reset_n           = 1'b1;
    buf_in_ready      = 1'b0;
    buf_in_commit_ack = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    checkAllZero("reset");
    tick();
    tick();
    reset_n = 1'b1;

    // Endpoint buffer not ready: upstream held off, nothing written.
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("not_ready_s_ready", {31'd0, s_ready}, 32'd0);
    end
    buf_in_ready      = 1'b1;
    buf_in_commit_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("ack_high_s_ready", {31'd0, s_ready}, 32'd0);
    end
    buf_in_commit_ack = 1'b0;
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("enter_fill_s_ready", {31'd0, s_ready}, 32'd1);
    checkOutput("no_write_before_fill", obs_q.size(), 32'd0);
    checkOutput("no_commit_before_fill", {31'd0, buf_in_commit}, 32'd0);

    // Three-byte packet A1 A2 A3 with s_last; ack held off for 10 cycles.
    sendByte(8'hA1, 1'b0, 1'b0);
    sendByte(8'hA2, 1'b0, 1'b0);
    sendByte(8'hA3, 1'b1, 1'b0);
    checkOutput("a3_wren", {31'd0, buf_in_wren}, 32'd1);
    checkOutput("a3_addr", {23'd0, buf_in_addr}, 32'd2);
    checkOutput("a3_data", {24'd0, buf_in_data}, 32'hA3);
    checkOutput("a3_commit_early", {31'd0, buf_in_commit}, 32'd0);
    checkOutput("a3_s_ready", {31'd0, s_ready}, 32'd0);
    tick();
    checkOutput("a3_commit", {31'd0, buf_in_commit}, 32'd1);
    checkOutput("a3_wren_done", {31'd0, buf_in_wren}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 8'hEE, 1'b1, 1'b1);
      tick();
      checkOutput("hold_commit", {31'd0, buf_in_commit}, 32'd1);
      checkOutput("hold_len", {22'd0, buf_in_commit_len}, 32'd3);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    finishPacket("pkt3", 4);

    // Flush with an empty buffer commits a zero-length packet.
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    finishPacket("zlp", 4);

    // Random packets with idle gaps; buf_in_ready wanders during fill, and
    // one packet ends with flush on its final byte instead of s_last.
    for (int p = 0; p < 4; p++) begin
      plen = $urandom_range(1, 40);
      for (int i = 0; i < plen; i++) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          tick();
        end
        buf_in_ready = 1'($urandom_range(0, 1));
        d = 8'($urandom);
        if (i == plen - 1) begin
          sendByte(d, (p != 2), (p == 2));
        end else begin
          sendByte(d, 1'b0, 1'b0);
        end
      end
      buf_in_ready = 1'b1;
      finishPacket($sformatf("rnd%0d", p), 4);
    end

    // Full-size packet closes on the 512th byte.
    for (int i = 0; i < MAX_PKT; i++) begin
      sendByte(8'(i), 1'b0, 1'b0);
    end
    checkOutput("full_s_ready_low", {31'd0, s_ready}, 32'd0);
    finishPacket("full", 4);

    // Partial packet left idle.
    for (int i = 0; i < 5; i++) begin
      sendByte(8'($urandom), 1'b0, 1'b0);
    end
`ifdef USB_IN_TIMEOUT_EN
    waited = 0;
    while (buf_in_commit !== 1'b1 && waited < 4 * TMO) begin
      tick();
      waited++;
    end
    checkOutput("timeout_delay", waited, TMO + 1);
    finishPacket("timeout", 2);
`else
    waited = 0;
    for (int i = 0; i < 4 * TMO; i++) begin
      tick();
      if (buf_in_commit === 1'b1) waited++;
    end
    checkOutput("no_timeout_commit", waited, 32'd0);
    checkOutput("no_timeout_busy", {31'd0, stat_busy}, 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    finishPacket("late_flush", 4);
`endif

    // Reset in the middle of a packet discards it.
    for (int i = 0; i < 7; i++) begin
      sendByte(8'($urandom), 1'b0, 1'b0);
    end
    #1;
    reset_n = 1'b0;
    #1;
    checkAllZero("midreset");
    tick();
    reset_n = 1'b1;
    obs_q.delete();
    exp_q.delete();
    tick();
    checkOutput("post_reset_fill", {31'd0, s_ready}, 32'd1);
    checkOutput("post_reset_no_commit", {31'd0, buf_in_commit}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      sendByte(8'($urandom), (i == 3), 1'b0);
    end
    finishPacket("post_reset", 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
